// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU and its iterative mul/div unit.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SHL = 4'b0101,
        OP_SHR = 4'b0110,
        OP_SRA = 4'b0111,
        OP_MUL = 4'b1000,
        OP_DIV = 4'b1001
    } alu_op_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider sharing one hi/lo register pair.
// done and lo/hi are combinational on the final step so the owner can register them that edge.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    localparam int CW = $clog2(WIDTH);

    // hi = accumulator / remainder, lo = multiplier / quotient
    logic [WIDTH-1:0] hi_q, lo_q, b_q, hi_d, lo_d;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, div_q;
    logic [WIDTH:0]   sum, sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum  = '0;
        sh   = '0;
        diff = '0;
        ge   = 1'b0;
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_q) begin
            sh   = {hi_q, lo_q[WIDTH-1]};
            ge   = (sh >= {1'b0, b_q});
            diff = sh[WIDTH-1:0] - b_q;
            hi_d = ge ? diff : sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ge};
        end else begin
            sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign done = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign lo   = lo_d;
    assign hi   = hi_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            div_q  <= (op == OP_DIV);
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= a;
            b_q    <= b;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (done) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready on both sides: single-cycle logic/arith/shift ops,
// iterative unsigned MUL/DIV, NZVC flags; result held in DONE until the consumer takes it.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       nzvc_flags,
    output logic             div_by_zero
);
    state_t           state_q;
    logic [WIDTH-1:0] result_q, result_hi_q;
    logic [3:0]       flags_q;
    logic             dbz_q, div_q, bz_q;

    alu_op_t          op;
    logic             is_md, start, md_done;
    logic [WIDTH-1:0] md_lo, md_hi;

    logic [WIDTH-1:0] res_d;
    logic [3:0]       flags_d;
    logic             c_d, v_d, ok_d;
    logic [WIDTH:0]   add_t, sub_t, shl_t, shr_t;
    logic signed [WIDTH:0] sra_t;
    logic [SHW-1:0]   amt;

    assign op    = alu_op_t'(alu_control);
    assign is_md = (op == OP_MUL) || (op == OP_DIV);
    assign start = (state_q == IDLE) && in_valid && is_md;
    assign amt   = src_b[SHW-1:0];

    // Shifts run on a one-bit-extended operand so the extra bit is the last bit shifted out.
    always_comb begin
        add_t = {1'b0, src_a} + {1'b0, src_b};
        sub_t = {1'b0, src_a} - {1'b0, src_b};
        shl_t = {1'b0, src_a} << amt;
        shr_t = {src_a, 1'b0} >> amt;
        sra_t = $signed({src_a, 1'b0}) >>> amt;
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        ok_d  = 1'b1;
        case (op)
            OP_ADD: begin
                res_d = add_t[WIDTH-1:0];
                c_d   = add_t[WIDTH];
                v_d   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (res_d[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = sub_t[WIDTH-1:0];
                c_d   = ~sub_t[WIDTH];
                v_d   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (res_d[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND: res_d = src_a & src_b;
            OP_OR:  res_d = src_a | src_b;
            OP_XOR: res_d = src_a ^ src_b;
            OP_SHL: begin
                res_d = shl_t[WIDTH-1:0];
                c_d   = shl_t[WIDTH];
            end
            OP_SHR: begin
                res_d = shr_t[WIDTH:1];
                c_d   = shr_t[0];
            end
            OP_SRA: begin
                res_d = sra_t[WIDTH:1];
                c_d   = sra_t[0];
            end
            default: ok_d = 1'b0;
        endcase
        flags_d = '0;
        if (ok_d) begin
            flags_d[FLAG_N] = res_d[WIDTH-1];
            flags_d[FLAG_Z] = (res_d == '0);
            flags_d[FLAG_V] = v_d;
            flags_d[FLAG_C] = c_d;
        end
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (src_a),
        .b     (src_b),
        .done  (md_done),
        .lo    (md_lo),
        .hi    (md_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            dbz_q       <= 1'b0;
            div_q       <= 1'b0;
            bz_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    if (is_md) begin
                        state_q <= BUSY;
                        div_q   <= (op == OP_DIV);
                        bz_q    <= (src_b == '0);
                    end else begin
                        state_q     <= DONE;
                        result_q    <= res_d;
                        result_hi_q <= '0;
                        flags_q     <= flags_d;
                        dbz_q       <= 1'b0;
                    end
                end
                BUSY: if (md_done) begin
                    state_q             <= DONE;
                    result_q            <= md_lo;
                    result_hi_q         <= md_hi;
                    flags_q[FLAG_N]     <= md_lo[WIDTH-1];
                    flags_q[FLAG_Z]     <= (md_lo == '0);
                    flags_q[FLAG_V]     <= div_q ? bz_q : (md_hi != '0);
                    flags_q[FLAG_C]     <= div_q ? 1'b0 : (md_hi != '0);
                    dbz_q               <= div_q && bz_q;
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign nzvc_flags  = flags_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=4 with hand-computed results, flags and latency.
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready, div_by_zero;
    logic [3:0] src_a, src_b, alu_control, result, result_hi, nzvc_flags;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_hi   (result_hi),
        .nzvc_flags  (nzvc_flags),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge with the DUT idle.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] a,
                          input logic [3:0] b, input int lat, input logic [3:0] er,
                          input logic [3:0] eh, input logic [3:0] ef, input logic ed);
        int n;
        chk({tag, ".in_ready"}, in_ready, 1);
        in_valid = 1'b1; alu_control = op; src_a = a; src_b = b;
        step();
        in_valid = 1'b0; alu_control = 4'hF; src_a = ~a; src_b = ~b;
        n = 1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, ".lat"}, n, lat);
        chk({tag, ".res"}, result, er);
        chk({tag, ".hi"}, result_hi, eh);
        chk({tag, ".nzvc"}, nzvc_flags, ef);
        chk({tag, ".dbz"}, div_by_zero, ed);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".released"}, out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        src_a = '0; src_b = '0; alu_control = '0;
        step(); step();
        rst = 1'b0;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.res", result, 0);
        chk("rst.hi", result_hi, 0);
        chk("rst.nzvc", nzvc_flags, 0);
        chk("rst.dbz", div_by_zero, 0);

        //      tag        op       a        b        lat  res      hi       nzvc     dbz
        run_op("add_ovf",  4'b0000, 4'b0111, 4'b0001, 1, 4'b1000, 4'b0000, 4'b1010, 1'b0);
        run_op("add_cry",  4'b0000, 4'b1111, 4'b0001, 1, 4'b0000, 4'b0000, 4'b0101, 1'b0);
        run_op("sub_neg",  4'b0001, 4'b0001, 4'b0111, 1, 4'b1010, 4'b0000, 4'b1000, 1'b0);
        run_op("sub_eq",   4'b0001, 4'b0101, 4'b0101, 1, 4'b0000, 4'b0000, 4'b0101, 1'b0);
        run_op("and",      4'b0010, 4'b1100, 4'b1010, 1, 4'b1000, 4'b0000, 4'b1000, 1'b0);
        run_op("or_zero",  4'b0011, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0100, 1'b0);
        run_op("xor",      4'b0100, 4'b1010, 4'b0110, 1, 4'b1100, 4'b0000, 4'b1000, 1'b0);
        run_op("shl1",     4'b0101, 4'b1011, 4'b0001, 1, 4'b0110, 4'b0000, 4'b0001, 1'b0);
        run_op("shl0",     4'b0101, 4'b0101, 4'b0100, 1, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        run_op("shr2",     4'b0110, 4'b1011, 4'b0110, 1, 4'b0010, 4'b0000, 4'b0001, 1'b0);
        run_op("sra3",     4'b0111, 4'b1000, 4'b0011, 1, 4'b1111, 4'b0000, 4'b1000, 1'b0);
        run_op("sra1",     4'b0111, 4'b1001, 4'b0001, 1, 4'b1100, 4'b0000, 4'b1001, 1'b0);
        run_op("bad_op",   4'b1111, 4'b0011, 4'b0101, 1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        run_op("mul",      4'b1000, 4'b0111, 4'b0011, 5, 4'b0101, 4'b0001, 4'b0011, 1'b0);
        run_op("mul_max",  4'b1000, 4'b1111, 4'b1111, 5, 4'b0001, 4'b1110, 4'b0011, 1'b0);
        run_op("div",      4'b1001, 4'b0111, 4'b0010, 5, 4'b0011, 4'b0001, 4'b0000, 1'b0);
        run_op("div0",     4'b1001, 4'b0111, 4'b0000, 5, 4'b1111, 4'b0111, 4'b1010, 1'b1);

        // Consumer stalls 3 cycles while a new request is offered; it must be ignored.
        in_valid = 1'b1; alu_control = 4'b0000; src_a = 4'b0111; src_b = 4'b0001;
        step();
        alu_control = 4'b0001; src_a = 4'b0011; src_b = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            chk("hold.out_valid", out_valid, 1);
            chk("hold.in_ready", in_ready, 0);
            chk("hold.res", result, 4'b1000);
            chk("hold.nzvc", nzvc_flags, 4'b1010);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hold.release_idle", in_ready, 1);
        chk("hold.release_ov", out_valid, 0);
        step();
        chk("hold.no_ghost", out_valid, 0);

        // Reset during MUL step 2 must discard the operation entirely.
        run_op("pre_rst",  4'b0100, 4'b0110, 4'b1001, 1, 4'b1111, 4'b0000, 4'b1000, 1'b0);
        in_valid = 1'b1; alu_control = 4'b1000; src_a = 4'b0111; src_b = 4'b0011;
        step();
        in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst.in_ready", in_ready, 1);
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.res", result, 0);
        chk("midrst.hi", result_hi, 0);
        chk("midrst.nzvc", nzvc_flags, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("midrst.quiet", out_valid, 0);
        end
        run_op("post_rst", 4'b1000, 4'b0101, 4'b0011, 5, 4'b1111, 4'b0000, 4'b1000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
